// File: rtl/instruction_fetch.sv
// rtl/instruction_fetch.sv - ARMv8 fetch stage: PC generation, imem reads, in-order instruction queue; IF_UNCOND_PREDICT_EN enables fetch-time B/BL redirect
`timescale 1ns/1ps
module instruction_fetch #(
    parameter int          QUEUE_DEPTH = 4,
    parameter logic [63:0] RESET_PC    = 64'h0
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [63:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        id_stall,
    input  logic        redirect,
    input  logic [63:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] instruction,
    output logic [63:0] PC_out,
    output logic [63:0] PC_branch_link_out,
    output logic        pred_taken
);

    localparam int PTR_W = $clog2(QUEUE_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W:0]   DEPTH_W = (CNT_W+1)'(QUEUE_DEPTH);

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [63:0]      fetch_pc;
    logic [63:0]      resp_pc;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] outstanding_nxt;
    logic [CNT_W-1:0] drop_cnt;
    logic [CNT_W-1:0] drop_cnt_nxt;

    logic [31:0] q_instr [QUEUE_DEPTH];
    logic [63:0] q_pc    [QUEUE_DEPTH];

    logic        grant;
    logic        pop;
    logic        drop_resp;
    logic        accept;
    logic        predict;
    logic        flush;
    logic [63:0] new_pc;

    // Request while queued plus in-flight words still fit; held low in reset
    assign imem_req  = reset && (({1'b0, count} + {1'b0, outstanding}) < DEPTH_W);
    assign imem_addr = fetch_pc;

    assign grant     = imem_req && imem_gnt;
    assign pop       = if_valid && !id_stall;
    // Every response that arrives in FLUSH belongs to a stale, pre-redirect read
    assign drop_resp = imem_rvalid && (state_q == FLUSH);
    assign accept    = imem_rvalid && !drop_resp && !redirect;

`ifdef IF_UNCOND_PREDICT_EN
    logic        q_pred [QUEUE_DEPTH];
    logic [63:0] branch_target;

    // B/BL share opcode bits [30:26]; target is relative to the branch's own PC
    assign predict       = accept && (imem_rdata[30:26] == 5'b00101);
    assign branch_target = resp_pc + {{36{imem_rdata[25]}}, imem_rdata[25:0], 2'b00};
    assign new_pc        = redirect ? redirect_pc : branch_target;
    assign pred_taken    = if_valid && q_pred[head];

    // Prediction flag travels alongside the queued instruction
    always_ff @(posedge clock) begin
        if (accept) begin
            q_pred[tail] <= predict;
        end
    end
`else
    assign predict    = 1'b0;
    assign new_pc     = redirect_pc;
    assign pred_taken = 1'b0;
`endif

    assign flush = redirect || predict;

    // In-flight read count after this cycle's grant and response
    always_comb begin
        outstanding_nxt = outstanding;
        if (grant && !(imem_rvalid && (outstanding != '0))) begin
            outstanding_nxt = outstanding + CNT_ONE;
        end else if (!grant && imem_rvalid && (outstanding != '0)) begin
            outstanding_nxt = outstanding - CNT_ONE;
        end
    end

    // Stale reads to skip: everything still in flight once the path changes
    always_comb begin
        drop_cnt_nxt = drop_cnt;
        if (flush) begin
            drop_cnt_nxt = outstanding_nxt;
        end else if (drop_resp) begin
            drop_cnt_nxt = drop_cnt - CNT_ONE;
        end
    end

    // FSM next state: enter FLUSH while stale reads remain, leave when drained
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = (outstanding_nxt != '0) ? FLUSH : FETCH;
        end else if ((state_q == FLUSH) && (drop_cnt_nxt == '0)) begin
            state_d = FETCH;
        end
    end

    // FSM state register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // PCs, queue pointers and counters; a redirect overrides pop, write and grant
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            head        <= '0;
            tail        <= '0;
            count       <= '0;
            outstanding <= '0;
            drop_cnt    <= '0;
        end else begin
            outstanding <= outstanding_nxt;
            drop_cnt    <= drop_cnt_nxt;

            if (flush) begin
                fetch_pc <= new_pc;
                resp_pc  <= new_pc;
            end else begin
                if (grant) begin
                    fetch_pc <= fetch_pc + 64'd4;
                end
                if (accept) begin
                    resp_pc <= resp_pc + 64'd4;
                end
            end

            if (redirect) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (accept) begin
                    tail <= tail + PTR_ONE;
                end
                if (pop) begin
                    head <= head + PTR_ONE;
                end
                case ({accept, pop})
                    2'b10:   count <= count + CNT_ONE;
                    2'b01:   count <= count - CNT_ONE;
                    default: count <= count;
                endcase
            end
        end
    end

    // Queue payload storage; contents are only meaningful below count
    always_ff @(posedge clock) begin
        if (accept) begin
            q_instr[tail] <= imem_rdata;
            q_pc[tail]    <= resp_pc;
        end
    end

    // Head is presented directly; empty queue shows zero and the next PC to fill
    always_comb begin
        if_valid           = (count != '0);
        instruction        = if_valid ? q_instr[head] : 32'h0;
        PC_out             = if_valid ? q_pc[head] : resp_pc;
        PC_branch_link_out = PC_out + 64'd4;
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb/tb_instruction_fetch.sv - directed self-checking bench for instruction_fetch
`timescale 1ns/1ps
module tb_instruction_fetch;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic        id_stall = 1'b0;
    logic        redirect = 1'b0;
    logic [63:0] redirect_pc = 64'h0;
    logic        if_valid;
    logic [31:0] instruction;
    logic [63:0] PC_out;
    logic [63:0] PC_branch_link_out;
    logic        pred_taken;

    instruction_fetch #(.QUEUE_DEPTH(4), .RESET_PC(64'h1000)) dut (
        .clock(clock), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .id_stall(id_stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .if_valid(if_valid), .instruction(instruction), .PC_out(PC_out),
        .PC_branch_link_out(PC_branch_link_out), .pred_taken(pred_taken)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int unsigned lat = 1;
    bit b_mode = 1'b0;
    int unsigned cyc = 0;
    int grants = 0;

    logic [63:0] m_addr[$];
    int unsigned m_due[$];
    logic [63:0] got_pc[$];
    logic [63:0] got_link[$];
    logic [31:0] got_ins[$];
    logic        got_pred[$];

    function automatic logic [31:0] mem_word(input logic [63:0] a);
        if (b_mode && a == 64'h1000) return 32'h1400_0004;
        return {8'hE0, a[23:0]};
    endfunction

    always @(posedge clock) cyc <= cyc + 1;

    // In-order memory with fixed latency; always grants
    always @(negedge clock) begin
        if (!reset) begin
            m_addr.delete();
            m_due.delete();
            imem_gnt = 1'b0;
            imem_rvalid = 1'b0;
            imem_rdata = 32'h0;
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata = 32'h0;
            if (m_due.size() > 0 && m_due[0] == cyc + 1) begin
                imem_rvalid = 1'b1;
                imem_rdata = mem_word(m_addr[0]);
                void'(m_addr.pop_front());
                void'(m_due.pop_front());
            end
            imem_gnt = imem_req;
            if (imem_req) begin
                m_addr.push_back(imem_addr);
                m_due.push_back(cyc + 1 + lat);
                grants++;
            end
        end
    end

    // Record instructions consumed by decode (squashed ones excluded)
    always @(negedge clock) begin
        if (reset && if_valid && !id_stall && !redirect) begin
            got_pc.push_back(PC_out);
            got_link.push_back(PC_branch_link_out);
            got_ins.push_back(instruction);
            got_pred.push_back(pred_taken);
        end
    end

    task automatic tick;
        @(posedge clock);
        #2;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_got;
        got_pc.delete();
        got_link.delete();
        got_ins.delete();
        got_pred.delete();
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " imem_req"}, {63'h0, imem_req}, 64'h0);
        chk({tag, " imem_addr"}, imem_addr, 64'h1000);
        chk({tag, " if_valid"}, {63'h0, if_valid}, 64'h0);
        chk({tag, " instruction"}, {32'h0, instruction}, 64'h0);
        chk({tag, " PC_out"}, PC_out, 64'h1000);
        chk({tag, " link"}, PC_branch_link_out, 64'h1004);
        chk({tag, " pred_taken"}, {63'h0, pred_taken}, 64'h0);
    endtask

    task automatic do_reset;
        reset = 1'b0;
        id_stall = 1'b0;
        redirect = 1'b0;
        redirect_pc = 64'h0;
        tick;
        tick;
        clear_got();
        grants = 0;
        reset = 1'b1;
    endtask

    task automatic wait_deliv(input int n, input string name);
        int k = 0;
        while (got_pc.size() < n && k < 200) begin
            tick;
            k++;
        end
        checks++;
        if (got_pc.size() < n) begin
            errors++;
            $display("FAIL %s: got %0d deliveries expected %0d", name, got_pc.size(), n);
        end
    endtask

    typedef struct {
        logic        stall;
        logic        exp_req;
        logic [63:0] exp_addr;
        logic        exp_valid;
        logic [63:0] exp_pc;
        logic [31:0] exp_ins;
    } vec_t;

    vec_t vecs[8];

    initial begin
        logic [63:0] exp_seq[$];

        // Rows sampled after each edge following reset release, latency 1
        vecs[0] = '{1'b0, 1'b1, 64'h1004, 1'b0, 64'h1000, 32'h0};
        vecs[1] = '{1'b0, 1'b1, 64'h1008, 1'b1, 64'h1000, 32'hE000_1000};
        vecs[2] = '{1'b0, 1'b1, 64'h100C, 1'b1, 64'h1004, 32'hE000_1004};
        vecs[3] = '{1'b0, 1'b1, 64'h1010, 1'b1, 64'h1008, 32'hE000_1008};
        vecs[4] = '{1'b1, 1'b1, 64'h1014, 1'b1, 64'h100C, 32'hE000_100C};
        vecs[5] = '{1'b0, 1'b1, 64'h1018, 1'b1, 64'h100C, 32'hE000_100C};
        vecs[6] = '{1'b0, 1'b1, 64'h101C, 1'b1, 64'h1010, 32'hE000_1010};
        vecs[7] = '{1'b0, 1'b1, 64'h1020, 1'b1, 64'h1014, 32'hE000_1014};

        // Reset state and first request
        lat = 1;
        tick;
        tick;
        chk_reset_outputs("reset");
        reset = 1'b1;
        #1;
        chk("first req", {63'h0, imem_req}, 64'h1);
        chk("first addr", imem_addr, 64'h1000);
        for (int i = 0; i < 8; i++) begin
            tick;
            chk($sformatf("row%0d req", i), {63'h0, imem_req}, {63'h0, vecs[i].exp_req});
            chk($sformatf("row%0d addr", i), imem_addr, vecs[i].exp_addr);
            chk($sformatf("row%0d valid", i), {63'h0, if_valid}, {63'h0, vecs[i].exp_valid});
            chk($sformatf("row%0d pc", i), PC_out, vecs[i].exp_pc);
            chk($sformatf("row%0d link", i), PC_branch_link_out, vecs[i].exp_pc + 64'd4);
            chk($sformatf("row%0d ins", i), {32'h0, instruction}, {32'h0, vecs[i].exp_ins});
            id_stall = vecs[i].stall;
        end

        // Stall from start: four grants, then frozen on 0x1000
        do_reset();
        id_stall = 1'b1;
        for (int i = 0; i < 10; i++) tick;
        chk("stall grants", 64'(grants), 64'd4);
        chk("stall req", {63'h0, imem_req}, 64'h0);
        chk("stall valid", {63'h0, if_valid}, 64'h1);
        chk("stall pc", PC_out, 64'h1000);
        clear_got();
        id_stall = 1'b0;
        for (int i = 0; i < 8; i++) tick;
        chk("unstall count", 64'(got_pc.size()), 64'd8);
        for (int i = 0; i < 8; i++)
            chk($sformatf("unstall pc%0d", i), got_pc[i], 64'h1000 + 64'(4 * i));

        // Latency 3: redirect with three reads outstanding
        lat = 3;
        do_reset();
        tick;
        tick;
        tick;
        redirect = 1'b1;
        redirect_pc = 64'h2000;
        tick;
        redirect = 1'b0;
        chk("redir valid", {63'h0, if_valid}, 64'h0);
        chk("redir req", {63'h0, imem_req}, 64'h1);
        chk("redir addr", imem_addr, 64'h2000);
        wait_deliv(4, "redir deliveries");
        for (int i = 0; i < 4; i++)
            chk($sformatf("redir pc%0d", i), got_pc[i], 64'h2000 + 64'(4 * i));

        // Redirect coinciding with a response and a pop
        lat = 1;
        do_reset();
        for (int i = 0; i < 4; i++) tick;
        redirect = 1'b1;
        redirect_pc = 64'h3000;
        tick;
        redirect = 1'b0;
        chk("same-cycle empty", {63'h0, if_valid}, 64'h0);
        wait_deliv(6, "same-cycle deliveries");
        exp_seq = '{64'h1000, 64'h1004, 64'h3000, 64'h3004, 64'h3008, 64'h300C};
        for (int i = 0; i < 6; i++)
            chk($sformatf("same-cycle pc%0d", i), got_pc[i], exp_seq[i]);

        // PC wrap across 2^64
        do_reset();
        tick;
        tick;
        redirect = 1'b1;
        redirect_pc = 64'hFFFF_FFFF_FFFF_FFF8;
        tick;
        redirect = 1'b0;
        wait_deliv(4, "wrap deliveries");
        exp_seq = '{64'hFFFF_FFFF_FFFF_FFF8, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0, 64'h4};
        for (int i = 0; i < 4; i++)
            chk($sformatf("wrap pc%0d", i), got_pc[i], exp_seq[i]);
        chk("wrap link", got_link[1], 64'h0);
        chk("wrap ins", {32'h0, got_ins[2]}, 64'hE000_0000);

        // Unconditional branch at 0x1000, imm26 = 4
        b_mode = 1'b1;
        do_reset();
        wait_deliv(2, "branch deliveries");
        chk("branch ins", {32'h0, got_ins[0]}, 64'h1400_0004);
        chk("branch pc0", got_pc[0], 64'h1000);
`ifdef IF_UNCOND_PREDICT_EN
        chk("branch pred0", {63'h0, got_pred[0]}, 64'h1);
        chk("branch pc1", got_pc[1], 64'h1010);
`else
        chk("branch pred0", {63'h0, got_pred[0]}, 64'h0);
        chk("branch pc1", got_pc[1], 64'h1004);
`endif
        chk("branch pred1", {63'h0, got_pred[1]}, 64'h0);
        b_mode = 1'b0;

        // Reset pulsed with two reads outstanding
        lat = 2;
        do_reset();
        tick;
        tick;
        tick;
        chk("pre-reset valid", {63'h0, if_valid}, 64'h1);
        reset = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        tick;
        tick;
        clear_got();
        reset = 1'b1;
        wait_deliv(3, "restart deliveries");
        for (int i = 0; i < 3; i++)
            chk($sformatf("restart pc%0d", i), got_pc[i], 64'h1000 + 64'(4 * i));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, limit 200000 ns");
        $fatal(1);
    end

endmodule
